quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 8: position counter width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: flip-flop stages in each input synchronizer.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enc_a  input  1  quadrature channel A, asynchronous to clk.
REQ-006 enc_b  input  1  quadrature channel B, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of count, active-high.
REQ-008 err_clr  input  1  clears the sticky error flag, active-high.
REQ-009 count  output  WIDTH  signed-agnostic position count.
REQ-010 step  output  1  one-cycle pulse on each valid transition.
REQ-011 dir  output  1  direction of last valid transition; 1 = up, 0 = down.
REQ-012 err  output  1  sticky illegal-transition flag.

Function
REQ-013 enc_a and enc_b SHALL each pass through a SYNC_STAGES-deep synchronizer before any use; the synchronized pair forms state S = {A,B}.
REQ-014 FSM states: INIT and RUN; INIT SHALL last exactly SYNC_STAGES+1 cycles after reset deasserts, then SHALL load S into the previous-state register P and enter RUN, with no count, step or err activity.
REQ-015 In RUN, the up sequence SHALL be 00->10->11->01->00; each such P->S change SHALL increment count by 1, pulse step, and set dir=1.
REQ-016 In RUN, the reverse sequence SHALL decrement count by 1, pulse step, and set dir=0.
REQ-017 S equal to P SHALL cause no change to count, step or dir.
REQ-018 A two-bit change (00<->11, 10<->01) SHALL set err=1, leave count and dir unchanged, and hold step at 0.
REQ-019 P SHALL update to S every RUN cycle, including after an illegal transition.
REQ-020 Latency: a change on enc_a/enc_b first sampled at edge k SHALL be reflected in count, step and dir at edge k+SYNC_STAGES+1.
REQ-021 Count SHALL wrap modulo 2^WIDTH: 2^WIDTH-1 up -> 0; 0 down -> 2^WIDTH-1.
REQ-022 clr SHALL force count to 0 on the same edge and SHALL override a simultaneous increment or decrement; step and dir SHALL still report that transition.
REQ-023 When err_clr and a new illegal transition occur on the same edge, err SHALL end at 1 (set wins).
REQ-024 step SHALL never be high for two consecutive cycles unless two valid transitions arrive on consecutive cycles.

Reset
REQ-025 On rst: count=0, step=0, dir=1, err=0, FSM=INIT, INIT cycle counter=0, P=00, synchronizer flops=0.
REQ-026 rst SHALL take priority over clr, err_clr and all transitions.
REQ-027 rst asserted mid-operation SHALL apply all values in REQ-025 on the next edge and rerun INIT.

Structure
REQ-028 Shared package quad_pkg SHALL hold the FSM state encoding (INIT, RUN) and the 2-bit Gray-state constants (00, 10, 11, 01).
REQ-029 A single-bit synchronizer sub-module sync_ff, parameterized by stage count, SHALL be instantiated once per channel.
REQ-030 Transition classification (up/down/none/illegal) SHALL be combinational from {P,S}; everything else is registered.

Verification
REQ-031 rst with enc_a=enc_b=1 held -> after INIT: count=0, err=0, step never pulses.
REQ-032 From 00, apply 00->10->11->01->00, each held 5 cycles -> count=4, exactly 4 step pulses, dir=1, each pulse SYNC_STAGES+1 edges after its input change.
REQ-033 From count=0, apply 00->01 -> count=255 (WIDTH=8), dir=0, one step pulse.
REQ-034 Apply 00->11 -> err=1, count unchanged, no step; err_clr pulse -> err=0; err_clr coincident with 10->01 -> err=1.
REQ-035 clr asserted on the same edge as an up step at count=9 -> count=0, step=1, dir=1.
REQ-036 rst pulsed at count=37 while the encoder is moving -> count=0, dir=1, err=0 next edge; counting resumes only after INIT completes.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: FSM states, Gray-code
// encoder states and the transition classifier.
package quad_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TR_NONE = 2'd0,
        TR_UP   = 2'd1,
        TR_DN   = 2'd2,
        TR_ILL  = 2'd3
    } trans_t;

    // Encoder states {A,B} in up-count order
    localparam logic [1:0] GRAY_00 = 2'b00;
    localparam logic [1:0] GRAY_10 = 2'b10;
    localparam logic [1:0] GRAY_11 = 2'b11;
    localparam logic [1:0] GRAY_01 = 2'b01;

    // Successor of s when the encoder moves in the up direction
    function automatic logic [1:0] gray_next_up(input logic [1:0] s);
        logic [1:0] n;
        n = GRAY_00;
        case (s)
            GRAY_00: n = GRAY_10;
            GRAY_10: n = GRAY_11;
            GRAY_11: n = GRAY_01;
            GRAY_01: n = GRAY_00;
            default: n = GRAY_00;
        endcase
        return n;
    endfunction

    // Classify a previous/current state pair
    function automatic trans_t classify(input logic [1:0] p, input logic [1:0] s);
        trans_t t;
        if (s == p)
            t = TR_NONE;
        else if (s == gray_next_up(p))
            t = TR_UP;
        else if (p == gray_next_up(s))
            t = TR_DN;
        else
            t = TR_ILL;
        return t;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchronizer for an asynchronous input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the input through the synchronizer chain
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_sync <= '0;
        else
            r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, classifies each state
// change and maintains a wrapping position count with step/dir/err flags.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err
);

    logic             w_a;
    logic             w_b;
    logic [1:0]       w_s;
    trans_t           w_trans;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_init_done;
    logic [2:0]       r_init_cnt;
    logic [1:0]       r_p;
    logic             r_up;
    logic             r_dn;
    logic             r_ill;
    logic [WIDTH-1:0] r_count;
    logic             r_step;
    logic             r_dir;
    logic             r_err;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (enc_a),
        .o_q   (w_a)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (enc_b),
        .o_q   (w_b)
    );

    assign w_s     = {w_a, w_b};
    assign w_trans = classify(r_p, w_s);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_INIT;
        else
            r_state <= w_state_nxt;
    end

    // Leave INIT once the synchronizers hold fresh encoder samples
    always_comb begin
        w_state_nxt = r_state;
        w_init_done = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == 3'(SYNC_STAGES)) begin
                    w_init_done = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Count cycles spent in INIT
    always_ff @(posedge clk) begin
        if (rst)
            r_init_cnt <= '0;
        else if (r_state == ST_INIT && !w_init_done)
            r_init_cnt <= r_init_cnt + 3'd1;
    end

    // Track previous state and register the classified transition;
    // the registered flags add the one cycle of latency after the sync chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p   <= GRAY_00;
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
            r_ill <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_p   <= w_s;
            r_up  <= (w_trans == TR_UP);
            r_dn  <= (w_trans == TR_DN);
            r_ill <= (w_trans == TR_ILL);
        end else begin
            if (w_init_done)
                r_p <= w_s;
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
            r_ill <= 1'b0;
        end
    end

    // Update count, step, dir and sticky error from the registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_step <= r_up | r_dn;
            if (clr)
                r_count <= '0;
            else if (r_up)
                r_count <= r_count + WIDTH'(1);
            else if (r_dn)
                r_count <= r_count - WIDTH'(1);
            if (r_up)
                r_dir <= 1'b1;
            else if (r_dn)
                r_dir <= 1'b0;
            r_err <= r_ill | (r_err & ~err_clr);
        end
    end

    assign count = r_count;
    assign step  = r_step;
    assign dir   = r_dir;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: each encoder move pushes its expected
// outcome tagged with the edge it must appear on; a monitor pops and checks.
module tb_quad_decoder;

    localparam int N = 2;
    localparam int W = 8;

    typedef struct {
        int         due;
        logic       step;
        logic [7:0] count;
        logic       dir;
        logic       err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enc_a = 1'b0;
    logic         enc_b = 1'b0;
    logic         clr = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] count;
    logic         step;
    logic         dir;
    logic         err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_steps = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    logic [1:0] m_ab    = 2'b00;
    logic [7:0] m_count = 8'd0;
    logic       m_dir   = 1'b1;
    logic       m_err   = 1'b0;
    logic [7:0] exp_count = 8'd0;

    quad_decoder #(.WIDTH(W), .SYNC_STAGES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clr     (clr),
        .err_clr (err_clr),
        .count   (count),
        .step    (step),
        .dir     (dir),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] up_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] dn_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Pop expected results on their due edge; otherwise nothing may move
    always @(negedge clk) begin
        if (mon_en) begin
            if (step === 1'b1)
                n_steps++;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                chk("due_step",  32'(step),  32'(mon_e.step));
                chk("due_count", 32'(count), 32'(mon_e.count));
                chk("due_dir",   32'(dir),   32'(mon_e.dir));
                chk("due_err",   32'(err),   32'(mon_e.err));
                exp_count = mon_e.count;
            end else begin
                chk("idle_step",  32'(step),  32'(1'b0));
                chk("idle_count", 32'(count), 32'(exp_count));
            end
        end
    end

    task automatic move(input logic [1:0] ab, input int hold, input bit do_clr, input bit do_eclr);
        exp_t e;
        bit   push;
        bit   ill;
        @(posedge clk);
        #1;
        enc_a = ab[1];
        enc_b = ab[0];
        push = 1'b1;
        ill  = 1'b0;
        e.step = 1'b0;
        if (ab == up_of(m_ab)) begin
            m_count++;
            m_dir  = 1'b1;
            e.step = 1'b1;
        end else if (ab == dn_of(m_ab)) begin
            m_count--;
            m_dir  = 1'b0;
            e.step = 1'b1;
        end else if (ab != m_ab) begin
            m_err = 1'b1;
            ill   = 1'b1;
        end else begin
            push = 1'b0;
        end
        if (do_clr)
            m_count = 8'd0;
        if (do_eclr && !ill)
            m_err = 1'b0;
        m_ab    = ab;
        e.due   = cyc + N + 2;
        e.count = m_count;
        e.dir   = m_dir;
        e.err   = m_err;
        if (push)
            sb.push_back(e);
        if (do_clr || do_eclr) begin
            repeat (N + 1) @(posedge clk);
            #1;
            clr     = do_clr;
            err_clr = do_eclr;
            @(posedge clk);
            #1;
            clr     = 1'b0;
            err_clr = 1'b0;
        end
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        enc_a = ab[1];
        enc_b = ab[0];
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_ab      = ab;
        m_count   = 8'd0;
        m_dir     = 1'b1;
        m_err     = 1'b0;
        exp_count = 8'd0;
        mon_en    = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr", 32'(err), 32'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with encoder parked at 11: no activity after INIT
        do_reset(2'b11);
        chk("rst11_count", 32'(count), 32'(0));
        chk("rst11_err",   32'(err),   32'(0));
        chk("rst11_dir",   32'(dir),   32'(1));
        chk("rst11_steps", n_steps, 0);

        // Full up cycle, each state held 5 cycles
        do_reset(2'b00);
        n_steps = 0;
        move(2'b10, 5, 1'b0, 1'b0);
        move(2'b11, 5, 1'b0, 1'b0);
        move(2'b01, 5, 1'b0, 1'b0);
        move(2'b00, 5, 1'b0, 1'b0);
        drain();
        chk("up4_count", 32'(count), 32'(4));
        chk("up4_dir",   32'(dir),   32'(1));
        chk("up4_steps", n_steps, 4);

        // Down from zero wraps to 255, then up wraps back to 0
        do_reset(2'b00);
        n_steps = 0;
        move(2'b01, 5, 1'b0, 1'b0);
        drain();
        chk("dnwrap_count", 32'(count), 32'(255));
        chk("dnwrap_dir",   32'(dir),   32'(0));
        chk("dnwrap_steps", n_steps, 1);
        move(2'b00, 5, 1'b0, 1'b0);
        drain();
        chk("upwrap_count", 32'(count), 32'(0));

        // Illegal jump, error clear, then clear coincident with a new illegal jump
        move(2'b11, 5, 1'b0, 1'b0);
        drain();
        chk("ill_err",   32'(err),   32'(1));
        chk("ill_count", 32'(count), 32'(0));
        chk("ill_dir",   32'(dir),   32'(1));
        pulse_err_clr();
        move(2'b10, 5, 1'b0, 1'b0);
        move(2'b01, 5, 1'b0, 1'b1);
        drain();
        chk("ill2_err",   32'(err),   32'(1));
        chk("ill2_count", 32'(count), 32'(255));

        // clr on the same edge as an up step at count 9
        do_reset(2'b00);
        for (int i = 0; i < 9; i++)
            move(up_of(m_ab), 2, 1'b0, 1'b0);
        drain();
        chk("pre_clr_count", 32'(count), 32'(9));
        move(up_of(m_ab), 4, 1'b1, 1'b0);
        drain();
        chk("clr_count", 32'(count), 32'(0));
        chk("clr_dir",   32'(dir),   32'(1));

        // Mid-motion reset at count 37 with err set and dir down
        do_reset(2'b00);
        for (int i = 0; i < 38; i++)
            move(up_of(m_ab), 1, 1'b0, 1'b0);
        move(m_ab ^ 2'b11, 5, 1'b0, 1'b0);
        move(dn_of(m_ab), 5, 1'b0, 1'b0);
        drain();
        chk("pre_rst_count", 32'(count), 32'(37));
        chk("pre_rst_dir",   32'(dir),   32'(0));
        chk("pre_rst_err",   32'(err),   32'(1));
        move(dn_of(m_ab), 1, 1'b0, 1'b0);
        move(dn_of(m_ab), 1, 1'b0, 1'b0);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_dir",   32'(dir),   32'(1));
        chk("rst_err",   32'(err),   32'(0));
        chk("rst_step",  32'(step),  32'(0));
        // Encoder jumps while INIT runs: must not count or flag
        rst   = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        sb.delete();
        m_ab      = 2'b00;
        m_count   = 8'd0;
        m_dir     = 1'b1;
        m_err     = 1'b0;
        exp_count = 8'd0;
        n_steps   = 0;
        mon_en    = 1'b1;
        repeat (N + 6) @(posedge clk);
        #1;
        chk("init_count", 32'(count), 32'(0));
        chk("init_err",   32'(err),   32'(0));
        chk("init_steps", n_steps, 0);
        move(2'b10, 5, 1'b0, 1'b0);
        drain();
        chk("resume_count", 32'(count), 32'(1));
        chk("resume_dir",   32'(dir),   32'(1));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
